// File: rtl/ahb2apb.sv
// AHB-Lite slave to APB master bridge, one transfer outstanding; ACCESS timeout enabled by AHB2APB_TIMEOUT_EN.
// Latency: read 3 data-phase cycles, write 4, plus one per pready-low ACCESS cycle.
// Backpressure: hreadyout low from accept until APB completes; pready low stalls ACCESS.
module ahb2apb #(
    parameter int A_WIDTH = 32,
    parameter int D_WIDTH = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hsel,
    input  logic [A_WIDTH-1:0] haddr,
    input  logic [1:0]         htrans,
    input  logic               hwrite,
    input  logic [D_WIDTH-1:0] hwdata,
    input  logic               hready,
    output logic               hreadyout,
    output logic               hresp,
    output logic [D_WIDTH-1:0] hrdata,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [A_WIDTH-1:0] paddr,
    output logic [D_WIDTH-1:0] pwdata,
    input  logic [D_WIDTH-1:0] prdata,
    input  logic               pready,
    input  logic               pslverr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   timeout_hit;
    logic   unused_ok;

    // htrans[0] only distinguishes NONSEQ from SEQ, which the bridge treats alike.
    assign unused_ok = htrans[0] | (TIMEOUT < 1);

    assign accept = ((state == IDLE) || (state == ERR2)) && hsel && hready && htrans[1];

`ifdef AHB2APB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] to_cnt;

    // Counts pready-low ACCESS cycles; the TIMEOUT-th one aborts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if ((state == ACCESS) && !pready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (to_cnt == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ERR2: state_nxt = accept ? (hwrite ? WDATA : SETUP) : IDLE;
            WDATA:      state_nxt = SETUP;
            SETUP:      state_nxt = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_nxt = pslverr ? ERR1 : IDLE;
                end else if (timeout_hit) begin
                    state_nxt = ERR1;
                end
            end
            ERR1:       state_nxt = ERR2;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            hrdata <= '0;
        end else begin
            if (accept) begin
                paddr  <= haddr;
                pwrite <= hwrite;
            end
            if (state == WDATA) begin
                pwdata <= hwdata;
            end
            if ((state == ACCESS) && pready && !pslverr && !pwrite) begin
                hrdata <= prdata;
            end
        end
    end

    assign psel      = (state == SETUP) || (state == ACCESS);
    assign penable   = (state == ACCESS);
    assign hreadyout = (state == IDLE) || (state == ERR2);
    assign hresp     = (state == ERR1) || (state == ERR2);

endmodule

// File: tb/tb_ahb2apb.sv
// Directed bench for ahb2apb: read, write, wait states, slave error, async reset, filtering, timeout.
module tb_ahb2apb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    // {psel, penable, hreadyout, hresp}: IDLE 0010, WDATA 0000, SETUP 1000, ACCESS 1100, ERR1 0001, ERR2 0011
    wire [3:0] ctl = {psel, penable, hreadyout, hresp};

    always #5 clk_i = ~clk_i;

    ahb2apb #(.A_WIDTH(32), .D_WIDTH(32), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout),
        .hresp(hresp), .hrdata(hrdata), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hready = 1'b1;
    endtask

    task automatic no_xfer();
        hsel = 1'b0; htrans = 2'b00;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hwdata = '0; hready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #2;
        n_checks++; if (ctl !== 4'b0010) begin n_fail++; $display("FAIL rst_ctl got=%b exp=%b", ctl, 4'b0010); end
        n_checks++; if ({pwrite, paddr, pwdata, hrdata} !== 97'd0) begin n_fail++; $display("FAIL rst_regs got=%b/%h/%h/%h exp=0", pwrite, paddr, pwdata, hrdata); end
        tick(); tick();
        rst_i = 1'b0;
    endtask

    task automatic test_read();
        addr_phase(32'h10, 1'b0); prdata = 32'hDEADBEEF; pready = 1'b1; pslverr = 1'b0;
        tick();
        no_xfer();
        n_checks++; if (ctl !== 4'b1000) begin n_fail++; $display("FAIL rd_setup got=%b exp=%b", ctl, 4'b1000); end
        tick();
        n_checks++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL rd_access got=%b exp=%b", ctl, 4'b1100); end
        n_checks++; if ({pwrite, paddr} !== {1'b0, 32'h10}) begin n_fail++; $display("FAIL rd_addr got=%b/%h exp=0/00000010", pwrite, paddr); end
        tick();
        n_checks++; if (ctl !== 4'b0010) begin n_fail++; $display("FAIL rd_done got=%b exp=%b", ctl, 4'b0010); end
        n_checks++; if (hrdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", hrdata); end
    endtask

    task automatic test_write();
        addr_phase(32'h24, 1'b1); prdata = 32'hBAD0BAD0; pready = 1'b1;
        tick();
        no_xfer(); hwdata = 32'h12345678;
        n_checks++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL wr_wdata got=%b exp=%b", ctl, 4'b0000); end
        tick();
        hwdata = 32'hFFFFFFFF;
        n_checks++; if (ctl !== 4'b1000) begin n_fail++; $display("FAIL wr_setup got=%b exp=%b", ctl, 4'b1000); end
        tick();
        n_checks++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL wr_access got=%b exp=%b", ctl, 4'b1100); end
        n_checks++; if ({pwrite, paddr, pwdata} !== {1'b1, 32'h24, 32'h12345678}) begin n_fail++; $display("FAIL wr_apb got=%b/%h/%h exp=1/00000024/12345678", pwrite, paddr, pwdata); end
        tick();
        n_checks++; if (ctl !== 4'b0010) begin n_fail++; $display("FAIL wr_done got=%b exp=%b", ctl, 4'b0010); end
        n_checks++; if (hrdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_hrdata_hold got=%h exp=deadbeef", hrdata); end
    endtask

    task automatic test_wait_states();
        addr_phase(32'h30, 1'b0); pready = 1'b0; prdata = 32'h77777777;
        tick();
        addr_phase(32'h99, 1'b1);
        n_checks++; if (ctl !== 4'b1000) begin n_fail++; $display("FAIL ws_setup got=%b exp=%b", ctl, 4'b1000); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL ws_wait%0d got=%b exp=%b", i, ctl, 4'b1100); end
            n_checks++; if ({pwrite, paddr} !== {1'b0, 32'h30}) begin n_fail++; $display("FAIL ws_addr%0d got=%b/%h exp=0/00000030", i, pwrite, paddr); end
        end
        tick();
        no_xfer(); pready = 1'b1; prdata = 32'hCAFEF00D;
        n_checks++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL ws_last got=%b exp=%b", ctl, 4'b1100); end
        tick();
        n_checks++; if (ctl !== 4'b0010) begin n_fail++; $display("FAIL ws_done got=%b exp=%b", ctl, 4'b0010); end
        n_checks++; if (hrdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ws_data got=%h exp=cafef00d", hrdata); end
        tick();
        n_checks++; if (ctl !== 4'b0010) begin n_fail++; $display("FAIL ws_stay_idle got=%b exp=%b", ctl, 4'b0010); end
    endtask

    task automatic test_slverr();
        addr_phase(32'h40, 1'b1); pready = 1'b1; pslverr = 1'b1; prdata = 32'h11111111;
        tick();
        no_xfer(); hwdata = 32'hA5A5A5A5;
        tick();
        tick();
        n_checks++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL err_access got=%b exp=%b", ctl, 4'b1100); end
        tick();
        pslverr = 1'b0;
        n_checks++; if (ctl !== 4'b0001) begin n_fail++; $display("FAIL err_err1 got=%b exp=%b", ctl, 4'b0001); end
        n_checks++; if (hrdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_hrdata got=%h exp=cafef00d", hrdata); end
        tick();
        n_checks++; if (ctl !== 4'b0011) begin n_fail++; $display("FAIL err_err2 got=%b exp=%b", ctl, 4'b0011); end
        addr_phase(32'h44, 1'b0); prdata = 32'h55AA55AA;
        tick();
        no_xfer();
        n_checks++; if (ctl !== 4'b1000) begin n_fail++; $display("FAIL b2b_setup got=%b exp=%b", ctl, 4'b1000); end
        tick();
        n_checks++; if ({ctl, pwrite, paddr} !== {4'b1100, 1'b0, 32'h44}) begin n_fail++; $display("FAIL b2b_access got=%b/%b/%h exp=1100/0/00000044", ctl, pwrite, paddr); end
        tick();
        n_checks++; if (ctl !== 4'b0010) begin n_fail++; $display("FAIL b2b_done got=%b exp=%b", ctl, 4'b0010); end
        n_checks++; if (hrdata !== 32'h55AA55AA) begin n_fail++; $display("FAIL b2b_data got=%h exp=55aa55aa", hrdata); end
    endtask

    task automatic test_filter();
        logic [3:0] vec [4];
        vec[0] = 4'b0101;  // {hsel, htrans, hready}: unselected
        vec[1] = 4'b1001;  // IDLE
        vec[2] = 4'b1011;  // BUSY
        vec[3] = 4'b1100;  // hready low
        for (int i = 0; i < 4; i++) begin
            hsel = vec[i][3]; htrans = vec[i][2:1]; hready = vec[i][0];
            haddr = 32'hEE; hwrite = 1'b1;
            tick();
            n_checks++; if ({ctl, pwrite, paddr} !== {4'b0010, 1'b0, 32'h44}) begin n_fail++; $display("FAIL filt%0d got=%b/%b/%h exp=0010/0/00000044", i, ctl, pwrite, paddr); end
        end
        no_xfer(); hready = 1'b1;
    endtask

    task automatic test_reset_mid();
        addr_phase(32'h50, 1'b0); pready = 1'b0; prdata = 32'h12121212;
        tick();
        no_xfer();
        tick();
        n_checks++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL rm_access got=%b exp=%b", ctl, 4'b1100); end
        #2 rst_i = 1'b1;
        #1;
        n_checks++; if (ctl !== 4'b0010) begin n_fail++; $display("FAIL rm_async got=%b exp=%b", ctl, 4'b0010); end
        n_checks++; if ({pwrite, paddr, hrdata} !== 65'd0) begin n_fail++; $display("FAIL rm_regs got=%b/%h/%h exp=0", pwrite, paddr, hrdata); end
        tick();
        rst_i = 1'b0; pready = 1'b1; prdata = 32'h0F0F0F0F;
        addr_phase(32'h60, 1'b0);
        tick();
        no_xfer();
        n_checks++; if (ctl !== 4'b1000) begin n_fail++; $display("FAIL rm_setup got=%b exp=%b", ctl, 4'b1000); end
        tick();
        n_checks++; if ({ctl, paddr} !== {4'b1100, 32'h60}) begin n_fail++; $display("FAIL rm_access2 got=%b/%h exp=1100/00000060", ctl, paddr); end
        tick();
        n_checks++; if ({ctl, hrdata} !== {4'b0010, 32'h0F0F0F0F}) begin n_fail++; $display("FAIL rm_done got=%b/%h exp=0010/0f0f0f0f", ctl, hrdata); end
    endtask

    task automatic test_timeout();
        addr_phase(32'h70, 1'b0); pready = 1'b0; prdata = 32'h33333333;
        tick();
        no_xfer();
`ifdef AHB2APB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL to_access%0d got=%b exp=%b", i, ctl, 4'b1100); end
        end
        tick();
        n_checks++; if ({ctl, hrdata} !== {4'b0001, 32'h0F0F0F0F}) begin n_fail++; $display("FAIL to_err1 got=%b/%h exp=0001/0f0f0f0f", ctl, hrdata); end
        tick();
        n_checks++; if (ctl !== 4'b0011) begin n_fail++; $display("FAIL to_err2 got=%b exp=%b", ctl, 4'b0011); end
        tick();
        n_checks++; if (ctl !== 4'b0010) begin n_fail++; $display("FAIL to_idle got=%b exp=%b", ctl, 4'b0010); end
        pready = 1'b1;
`else
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL hang_access%0d got=%b exp=%b", i, ctl, 4'b1100); end
        end
        pready = 1'b1;
        tick();
        n_checks++; if ({ctl, hrdata} !== {4'b0010, 32'h33333333}) begin n_fail++; $display("FAIL hang_done got=%b/%h exp=0010/33333333", ctl, hrdata); end
`endif
    endtask

    initial begin
        test_reset();
        tick();
        test_read();
        test_write();
        test_wait_states();
        test_slverr();
        test_filter();
        test_reset_mid();
        test_timeout();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
